// File: rtl/multi_mode_counter_pkg.sv
// Shared definitions for the multi-mode counter and its round scheduler.
//   - Counter mode encodings (drive ctr_mode)
//   - Counter "who" encodings (reported on ctr_who / done_who)
//   - Scheduler FSM state type
package multi_mode_counter_pkg;

  localparam logic [1:0] COUNT_UP_BY_1   = 2'b00;
  localparam logic [1:0] COUNT_UP_BY_2   = 2'b01;
  localparam logic [1:0] COUNT_DOWN_BY_1 = 2'b10;
  localparam logic [1:0] COUNT_DOWN_BY_2 = 2'b11;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_LOSER  = 2'b01;
  localparam logic [1:0] WHO_WINNER = 2'b10;

  typedef enum logic [2:0] {
    CLR,
    IDLE,
    LOAD,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter.
// Ports:
//   clk     in  clock
//   rst     in  synchronous active-low reset (pointer -> requester 0)
//   req     in  [1:0] request vector
//   upd     in  pointer update strobe
//   upd_id  in  requester just served; priority moves to the other one
//   gnt     out [1:0] one-hot grant (combinational)
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  input  logic       upd_id,
  output logic [1:0] gnt
);

  logic ptr_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= 1'b0;
    end else if (upd) begin
      ptr_q <= ~upd_id;
    end
  end

  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = ptr_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

endmodule

// File: rtl/multi_mode_counter_sched.sv
// Round scheduler sharing one multi_mode_counter between two requesters.
// Grants one requester per round, loads the counter with that requester's
// mode/initial value, waits for GAMEOVER or a timeout, reports the result
// and keeps a saturating win score per requester.
// Ports:
//   clk, rst                      clock, synchronous active-low reset
//   req, req_mode0/1, req_val0/1  requester side
//   gnt                           one-hot grant (combinational, IDLE only)
//   ctr_rst, ctr_mode, ctr_init, ctr_init_val   counter control
//   ctr_gameover, ctr_who         counter status
//   busy, done, done_id, done_who, done_timeout  round status/result
//   score0, score1                saturating win counts
module multi_mode_counter_sched
  import multi_mode_counter_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 255,
  parameter int TO_W    = 8,
  parameter int SCORE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         req,
  input  logic [1:0]         req_mode0,
  input  logic [1:0]         req_mode1,
  input  logic [CNT_W-1:0]   req_val0,
  input  logic [CNT_W-1:0]   req_val1,
  output logic [1:0]         gnt,
  output logic               ctr_rst,
  output logic [1:0]         ctr_mode,
  output logic               ctr_init,
  output logic [CNT_W-1:0]   ctr_init_val,
  input  logic               ctr_gameover,
  input  logic [1:0]         ctr_who,
  output logic               busy,
  output logic               done,
  output logic               done_id,
  output logic [1:0]         done_who,
  output logic               done_timeout,
  output logic [SCORE_W-1:0] score0,
  output logic [SCORE_W-1:0] score1
);

  localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

  function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] s);
    return (&s) ? s : s + SCORE_W'(1);
  endfunction

  sched_state_t       state_q, state_d;
  logic               id_q;
  logic [1:0]         mode_q;
  logic [CNT_W-1:0]   val_q;
  logic [TO_W-1:0]    timer_q;
  logic               done_q;
  logic               done_id_q;
  logic [1:0]         done_who_q;
  logic               done_to_q;
  logic [SCORE_W-1:0] score0_q, score1_q;

  logic [1:0] arb_gnt;
  logic       arb_id;
  logic       grant_fire;
  logic       round_end;

  rr_arbiter2 u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (req),
    .upd    (state_q == DONE),
    .upd_id (id_q),
    .gnt    (arb_gnt)
  );

  assign arb_id     = arb_gnt[1];
  assign grant_fire = (state_q == IDLE) && (arb_gnt != 2'b00);
  // Gameover is tested first so it wins over a coincident timeout.
  assign round_end  = (state_q == RUN) && (ctr_gameover || (timer_q == TIMER_LAST));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= CLR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gnt      = 2'b00;
    ctr_init = 1'b0;
    // Counter is also held in reset while the scheduler itself is in reset.
    ctr_rst  = !rst;
    case (state_q)
      CLR: begin
        ctr_rst = 1'b1;
        state_d = IDLE;
      end
      IDLE: begin
        gnt = arb_gnt;
        if (grant_fire) state_d = LOAD;
      end
      LOAD: begin
        ctr_init = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        if (round_end) state_d = DONE;
      end
      DONE: begin
        // A timed-out counter may be stalled; clear it before the next round.
        if (done_to_q) ctr_rst = 1'b1;
        state_d = IDLE;
      end
      default: state_d = CLR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      id_q       <= 1'b0;
      mode_q     <= COUNT_UP_BY_1;
      val_q      <= '0;
      timer_q    <= '0;
      done_q     <= 1'b0;
      done_id_q  <= 1'b0;
      done_who_q <= WHO_NONE;
      done_to_q  <= 1'b0;
      score0_q   <= '0;
      score1_q   <= '0;
    end else begin
      if (grant_fire) begin
        id_q   <= arb_id;
        mode_q <= arb_id ? req_mode1 : req_mode0;
        val_q  <= arb_id ? req_val1 : req_val0;
      end

      if (state_q == LOAD) begin
        timer_q <= '0;
      end else if (state_q == RUN) begin
        timer_q <= timer_q + TO_W'(1);
      end

      done_q <= round_end;
      if (round_end) begin
        done_id_q  <= id_q;
        done_who_q <= ctr_gameover ? ctr_who : WHO_NONE;
        done_to_q  <= !ctr_gameover;
      end

      if ((state_q == DONE) && (done_who_q == WHO_WINNER)) begin
        if (id_q) score1_q <= sat_inc(score1_q);
        else      score0_q <= sat_inc(score0_q);
      end
    end
  end

  assign busy         = (state_q != IDLE);
  assign ctr_mode     = mode_q;
  assign ctr_init_val = val_q;
  assign done         = done_q;
  assign done_id      = done_id_q;
  assign done_who     = done_who_q;
  assign done_timeout = done_to_q;
  assign score0       = score0_q;
  assign score1       = score1_q;

endmodule

// File: tb/tb_multi_mode_counter_sched.sv
// Bench for multi_mode_counter_sched: the bench plays both the requesters and
// the counter, and predicts each round's grant, result and scores from a
// round-level model (priority flag, score array, last-result registers).
module tb_multi_mode_counter_sched;

  localparam int CNT_W   = 4;
  localparam int TIMEOUT = 4;
  localparam int TO_W    = 3;
  localparam int SCORE_W = 2;
  localparam int SMAX    = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic [1:0]         req = 2'b00;
  logic [1:0]         req_mode0 = 2'b00, req_mode1 = 2'b00;
  logic [CNT_W-1:0]   req_val0 = '0, req_val1 = '0;
  logic [1:0]         gnt;
  logic               ctr_rst;
  logic [1:0]         ctr_mode;
  logic               ctr_init;
  logic [CNT_W-1:0]   ctr_init_val;
  logic               ctr_gameover = 1'b0;
  logic [1:0]         ctr_who = 2'b00;
  logic               busy, done, done_id, done_timeout;
  logic [1:0]         done_who;
  logic [SCORE_W-1:0] score0, score1;

  multi_mode_counter_sched #(
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W), .SCORE_W(SCORE_W)
  ) dut (
    .clk(clk), .rst(rst), .req(req),
    .req_mode0(req_mode0), .req_mode1(req_mode1),
    .req_val0(req_val0), .req_val1(req_val1),
    .gnt(gnt), .ctr_rst(ctr_rst), .ctr_mode(ctr_mode), .ctr_init(ctr_init),
    .ctr_init_val(ctr_init_val), .ctr_gameover(ctr_gameover), .ctr_who(ctr_who),
    .busy(busy), .done(done), .done_id(done_id), .done_who(done_who),
    .done_timeout(done_timeout), .score0(score0), .score1(score1)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  // Round-level model
  int         m_prio;
  int         m_score[2];
  int         m_did;
  logic [1:0] m_dwho;
  int         m_dto;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_prio = 0; m_score[0] = 0; m_score[1] = 0;
    m_did = 0; m_dwho = 2'b00; m_dto = 0;
  endtask

  task automatic chk_held();
    chk("score0", 32'(score0), 32'(m_score[0]));
    chk("score1", 32'(score1), 32'(m_score[1]));
    chk("done_id_hold", 32'(done_id), 32'(m_did));
    chk("done_who_hold", 32'(done_who), 32'(m_dwho));
    chk("done_to_hold", 32'(done_timeout), 32'(m_dto));
  endtask

  // Called at negedge with rst already low; leaves the DUT in IDLE at negedge+1.
  task automatic reset_seq();
    req = 2'b00; ctr_gameover = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    model_reset();
    chk("rst_ctr_rst", 32'(ctr_rst), 1);
    chk("rst_busy", 32'(busy), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_ctr_init", 32'(ctr_init), 0);
    chk("rst_ctr_mode", 32'(ctr_mode), 0);
    chk("rst_init_val", 32'(ctr_init_val), 0);
    chk("rst_gnt", 32'(gnt), 0);
    chk_held();
    rst = 1'b1;
    #1;
    chk("clr_ctr_rst", 32'(ctr_rst), 1);
    chk("clr_busy", 32'(busy), 1);
    @(negedge clk);
    #1;
    chk("idle_busy", 32'(busy), 0);
    chk("idle_ctr_rst", 32'(ctr_rst), 0);
  endtask

  // k: RUN cycle index in which gameover is raised; k >= TIMEOUT means never.
  task automatic do_round(input logic [1:0] rq, input logic [1:0] m0, input logic [1:0] m1,
                          input logic [CNT_W-1:0] v0, input logic [CNT_W-1:0] v1,
                          input int k, input logic [1:0] w);
    int         id;
    logic [1:0] em;
    logic [CNT_W-1:0] ev;
    int         go;
    req = rq; req_mode0 = m0; req_mode1 = m1; req_val0 = v0; req_val1 = v1;
    ctr_gameover = 1'b0;
    id = (rq == 2'b11) ? m_prio : ((rq == 2'b10) ? 1 : 0);
    em = id ? m1 : m0;
    ev = id ? v1 : v0;
    go = (k < TIMEOUT) ? 1 : 0;
    #1;
    chk("gnt", 32'(gnt), 32'(2'b01 << id));
    chk("busy_idle", 32'(busy), 0);
    @(negedge clk);  // LOAD: requester inputs and gameover must be ignored
    req = 2'($urandom); req_mode0 = 2'($urandom); req_mode1 = 2'($urandom);
    req_val0 = CNT_W'($urandom); req_val1 = CNT_W'($urandom);
    ctr_gameover = 1'($urandom); ctr_who = 2'($urandom);
    #1;
    chk("load_init", 32'(ctr_init), 1);
    chk("load_mode", 32'(ctr_mode), 32'(em));
    chk("load_val", 32'(ctr_init_val), 32'(ev));
    chk("load_gnt", 32'(gnt), 0);
    chk("load_ctr_rst", 32'(ctr_rst), 0);
    for (int j = 0; j < TIMEOUT; j++) begin
      @(negedge clk);  // RUN cycle j
      ctr_gameover = (j == k); ctr_who = w; req = 2'($urandom);
      #1;
      chk("run_init", 32'(ctr_init), 0);
      chk("run_mode", 32'(ctr_mode), 32'(em));
      chk("run_ctr_rst", 32'(ctr_rst), 0);
      chk("run_busy", 32'(busy), 1);
      chk("run_done", 32'(done), 0);
      chk("run_gnt", 32'(gnt), 0);
      if (j == k || j == TIMEOUT - 1) break;
    end
    @(negedge clk);  // DONE
    ctr_gameover = 1'b0; req = 2'b00;
    m_did = id; m_dwho = go ? w : 2'b00; m_dto = go ? 0 : 1;
    #1;
    chk("done", 32'(done), 1);
    chk("done_ctr_rst", 32'(ctr_rst), 32'(m_dto));
    chk("done_busy", 32'(busy), 1);
    chk_held();
    if (go && w == 2'b10 && m_score[id] < SMAX) m_score[id]++;
    m_prio = 1 - id;
    @(negedge clk);  // back in IDLE
    #1;
    chk("post_done", 32'(done), 0);
    chk("post_busy", 32'(busy), 0);
    chk("post_ctr_rst", 32'(ctr_rst), 0);
    chk_held();
  endtask

  task automatic mid_round_reset();
    req = 2'b01; ctr_gameover = 1'b0;
    @(negedge clk);  // LOAD
    req = 2'b00;
    repeat (2) @(negedge clk);  // RUN cycle 1
    rst = 1'b0;
    #1;
    chk("midrst_ctr_rst_now", 32'(ctr_rst), 1);
    @(negedge clk);  // CLR
    #1;
    chk("midrst_busy", 32'(busy), 1);
    chk("midrst_done", 32'(done), 0);
    chk("midrst_score0", 32'(score0), 0);
    chk("midrst_score1", 32'(score1), 0);
    reset_seq();
  endtask

  initial begin
    rst = 1'b0;
    reset_seq();

    // Single requester 0, mode up1, value 3
    do_round(2'b01, 2'b00, 2'b11, 4'd3, 4'd9, 1, 2'b10);

    // Both requesting: grants alternate, each round a win
    for (int r = 0; r < 4; r++)
      do_round(2'b11, 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 0, 2'b10);

    // Timeout, then gameover coinciding with the last timer cycle
    do_round(2'b01, 2'b10, 2'b01, 4'd7, 4'd2, TIMEOUT, 2'b10);
    do_round(2'b10, 2'b01, 2'b11, 4'd5, 4'd12, TIMEOUT - 1, 2'b10);
    do_round(2'b11, 2'b11, 2'b00, 4'd1, 4'd15, TIMEOUT - 1, 2'b01);

    // Requester 0 wins repeatedly: score saturates
    for (int r = 0; r < 5; r++)
      do_round(2'b01, 2'($urandom), 2'($urandom), 4'($urandom), 4'($urandom), 2, 2'b10);
    chk("score0_sat", 32'(score0), 32'(SMAX));

    // Randomized rounds
    for (int r = 0; r < 40; r++)
      do_round(2'($urandom_range(1, 3)), 2'($urandom), 2'($urandom),
               4'($urandom), 4'($urandom), $urandom_range(0, TIMEOUT),
               ($urandom_range(0, 2) != 0) ? 2'b10 : 2'b01);

    mid_round_reset();
    do_round(2'b11, 2'b01, 2'b10, 4'd6, 4'd11, 0, 2'b10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
